// File: rtl/cache_perf_counters.sv
// Cache statistics collector for the L2, I-cache and D-cache controllers.
// Each cache has a small classifier that turns a request into exactly one
// hit or one miss event. Events feed six saturating 16-bit counters, each
// cleared by a committed store to its address in the 16'hFFF0..16'hFFF5 window.
//
// Handshake: a controller raises req and holds it until resp; resp and miss
// are sampled only on rising clk edges, there is no back-pressure toward the
// controllers, and a request is resolved once (hit, miss, or abort when req
// drops with no outcome).

module cache_perf_classifier (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req,
  input  logic       resp,
  input  logic       miss,
  output logic       hit_evt,
  output logic       miss_evt,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    MISS    = 2'd2
  } cls_state_e;

  cls_state_e state_q;
  cls_state_e state_d;

  // State register; reset abandons any in-flight request without counting it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and one-shot event decode; a long miss is counted only once.
  always_comb begin
    state_d  = state_q;
    hit_evt  = 1'b0;
    miss_evt = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (miss) begin
            miss_evt = 1'b1;
            state_d  = resp ? IDLE : MISS;
          end else if (resp) begin
            hit_evt = 1'b1;
          end else begin
            state_d = PENDING;
          end
        end
      end
      PENDING: begin
        if (miss) begin
          miss_evt = 1'b1;
          state_d  = resp ? IDLE : MISS;
        end else if (resp) begin
          hit_evt = 1'b1;
          state_d = IDLE;
        end else if (!req) begin
          state_d = IDLE;
        end
      end
      MISS: begin
        if (resp || !req) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign state = state_q;

endmodule

module cache_perf_counters (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        l2_req,
  input  logic        icache_req,
  input  logic        dcache_req,
  input  logic        l2_resp,
  input  logic        icache_resp,
  input  logic        dcache_resp,
  input  logic        l2_miss,
  input  logic        icache_miss,
  input  logic        dcache_miss,
  input  logic [15:0] mem_address,
  input  logic        clear_write,
  output logic [15:0] l2_miss_counter,
  output logic [15:0] l2_hit_counter,
  output logic [15:0] icache_miss_counter,
  output logic [15:0] icache_hit_counter,
  output logic [15:0] dcache_miss_counter,
  output logic [15:0] dcache_hit_counter,
  output logic [5:0]  saturated,
  output logic [5:0]  dbg_state
);

  // Counter index i matches the clear address 16'hFFF0 + i:
  // 0 l2_miss, 1 l2_hit, 2 icache_miss, 3 icache_hit, 4 dcache_miss, 5 dcache_hit.
  logic [5:0]  inc;
  logic [5:0]  clr;
  logic [5:0]  sat_q;
  logic [15:0] cnt_q [6];

  logic [1:0]  l2_state;
  logic [1:0]  ic_state;
  logic [1:0]  dc_state;

  cache_perf_classifier u_l2_cls (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (l2_req),
    .resp     (l2_resp),
    .miss     (l2_miss),
    .hit_evt  (inc[1]),
    .miss_evt (inc[0]),
    .state    (l2_state)
  );

  cache_perf_classifier u_ic_cls (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (icache_req),
    .resp     (icache_resp),
    .miss     (icache_miss),
    .hit_evt  (inc[3]),
    .miss_evt (inc[2]),
    .state    (ic_state)
  );

  cache_perf_classifier u_dc_cls (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (dcache_req),
    .resp     (dcache_resp),
    .miss     (dcache_miss),
    .hit_evt  (inc[5]),
    .miss_evt (inc[4]),
    .state    (dc_state)
  );

  // Decode the committed store address into one clear strobe per counter.
  always_comb begin
    clr = '0;
    for (int i = 0; i < 6; i++) begin
      clr[i] = clear_write && (mem_address == (16'hFFF0 + 16'(i)));
    end
  end

  for (genvar i = 0; i < 6; i++) begin : g_cnt
    // Saturating counter; a clear wins over a same-cycle event and drops it.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q[i] <= '0;
        sat_q[i] <= 1'b0;
      end else if (clr[i]) begin
        cnt_q[i] <= '0;
        sat_q[i] <= 1'b0;
      end else if (inc[i]) begin
        if (cnt_q[i] == 16'hFFFF) begin
          sat_q[i] <= 1'b1;
        end else begin
          cnt_q[i] <= cnt_q[i] + 16'd1;
        end
      end
    end
  end

  assign l2_miss_counter     = cnt_q[0];
  assign l2_hit_counter      = cnt_q[1];
  assign icache_miss_counter = cnt_q[2];
  assign icache_hit_counter  = cnt_q[3];
  assign dcache_miss_counter = cnt_q[4];
  assign dcache_hit_counter  = cnt_q[5];

  // Flag bits run opposite to the counter index: bit 0 is dcache_hit,
  // bit 2 icache_hit, bit 5 l2_miss.
  assign saturated = {sat_q[0], sat_q[1], sat_q[2], sat_q[3], sat_q[4], sat_q[5]};

  // Classifier states for debug: {dcache, icache, l2}, 0 idle, 1 pending, 2 miss.
  assign dbg_state = {dc_state, ic_state, l2_state};

endmodule
